// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding, timer width and score helpers for game_ctrl
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  localparam int         TIMER_W   = 16;
  localparam logic [3:0] SCORE_MAX = 4'd9;

  // Winning score selected by the two max_score bits.
  function automatic logic [3:0] target_of(input logic [1:0] sel);
    case (sel)
      2'b00:   target_of = 4'd3;
      2'b01:   target_of = 4'd5;
      2'b10:   target_of = 4'd7;
      default: target_of = 4'd9;
    endcase
  endfunction

  // Score increment that sticks at the display limit instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    sat_inc = (s >= SCORE_MAX) ? SCORE_MAX : s + 4'd1;
  endfunction

endpackage

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - frame_tick counter with synchronous clear and terminal-count flag
module tick_timer
  import game_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic               i_tick,
  input  logic [TIMER_W-1:0] i_limit,
  output logic               o_done
);

  logic [TIMER_W-1:0] r_count;
  logic [TIMER_W-1:0] w_count_inc;

  assign w_count_inc = r_count + 1'b1;

  // Flags the very tick that brings the count up to the limit.
  assign o_done = i_en && i_tick && (w_count_inc == i_limit);

  // Count enabled ticks; a clear always wins so each state entry restarts from zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && i_tick) begin
      r_count <= w_count_inc;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - match sequencing FSM: serve, play, point pause, scoring and game over
module game_ctrl
  import game_pkg::*;
#(
  parameter int AUTO_SERVE_FRAMES  = 120,
  parameter int POINT_PAUSE_FRAMES = 60
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_serve,
  input  logic       i_serve_type,
  input  logic [1:0] i_max_score,
  input  logic       i_frame_tick,
  input  logic       i_goal_p1,
  input  logic       i_goal_p2,
  output logic [3:0] o_score1,
  output logic [3:0] o_score2,
  output logic       o_ball_rst,
  output logic       o_ball_run,
  output logic       o_serve_dir,
  output logic       o_game_over,
  output logic       o_winner,
  output logic [2:0] o_state
);

  state_t     r_state,     w_state_nxt;
  logic [3:0] r_score1,    w_score1_nxt;
  logic [3:0] r_score2,    w_score2_nxt;
  logic [3:0] r_target,    w_target_nxt;
  logic       r_ball_rst,  w_ball_rst_nxt;
  logic       r_ball_run,  w_ball_run_nxt;
  logic       r_serve_dir, w_serve_dir_nxt;
  logic       r_game_over, w_game_over_nxt;
  logic       r_winner,    w_winner_nxt;
  logic       r_serve_q;
  logic       r_serve_d;

  logic               w_serve_rise;
  logic               w_timer_clr;
  logic               w_timer_en;
  logic               w_timer_done;
  logic [TIMER_W-1:0] w_timer_limit;

  // The raw button is registered first, then compared with its delayed copy;
  // both stages reset high so leaving reset never looks like a press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_serve_q <= 1'b1;
      r_serve_d <= 1'b1;
    end else begin
      r_serve_q <= i_serve;
      r_serve_d <= r_serve_q;
    end
  end

  assign w_serve_rise = r_serve_q && !r_serve_d;

  // One timer serves both the auto-serve wait and the post-goal pause; it
  // restarts whenever the FSM changes state.
  assign w_timer_clr   = (w_state_nxt != r_state);
  assign w_timer_en    = ((r_state == ST_SERVE) && i_serve_type) || (r_state == ST_POINT);
  assign w_timer_limit = (r_state == ST_POINT) ? TIMER_W'(POINT_PAUSE_FRAMES)
                                               : TIMER_W'(AUTO_SERVE_FRAMES);

  tick_timer u_tick_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_timer_clr),
    .i_en    (w_timer_en),
    .i_tick  (i_frame_tick),
    .i_limit (w_timer_limit),
    .o_done  (w_timer_done)
  );

  // Next state and next value of every registered output.
  always_comb begin
    w_state_nxt     = r_state;
    w_score1_nxt    = r_score1;
    w_score2_nxt    = r_score2;
    w_target_nxt    = r_target;
    w_serve_dir_nxt = r_serve_dir;
    w_winner_nxt    = r_winner;
    w_ball_rst_nxt  = 1'b0;

    if ((r_state != ST_IDLE) && !i_start) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            w_state_nxt     = ST_SERVE;
            w_target_nxt    = target_of(i_max_score);
            w_score1_nxt    = 4'd0;
            w_score2_nxt    = 4'd0;
            w_serve_dir_nxt = 1'b0;
            w_winner_nxt    = 1'b0;
            w_ball_rst_nxt  = 1'b1;
          end
        end
        ST_SERVE: begin
          if (w_serve_rise || w_timer_done) begin
            w_state_nxt = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (i_goal_p1 && i_goal_p2) begin
            w_state_nxt = ST_POINT;
          end else if (i_goal_p1) begin
            w_state_nxt     = ST_POINT;
            w_score2_nxt    = sat_inc(r_score2);
            w_serve_dir_nxt = 1'b0;
          end else if (i_goal_p2) begin
            w_state_nxt     = ST_POINT;
            w_score1_nxt    = sat_inc(r_score1);
            w_serve_dir_nxt = 1'b1;
          end
        end
        ST_POINT: begin
          if (w_timer_done) begin
            if ((r_score1 == r_target) || (r_score2 == r_target)) begin
              w_state_nxt  = ST_GAME_OVER;
              w_winner_nxt = (r_score2 == r_target);
            end else begin
              w_state_nxt    = ST_SERVE;
              w_ball_rst_nxt = 1'b1;
            end
          end
        end
        ST_GAME_OVER: begin
          w_state_nxt = ST_GAME_OVER;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    w_ball_rst_nxt  = w_ball_rst_nxt && !r_ball_rst;
    w_ball_run_nxt  = (w_state_nxt == ST_PLAY);
    w_game_over_nxt = (w_state_nxt == ST_GAME_OVER);
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_score1    <= 4'd0;
      r_score2    <= 4'd0;
      r_target    <= 4'd3;
      r_ball_rst  <= 1'b0;
      r_ball_run  <= 1'b0;
      r_serve_dir <= 1'b0;
      r_game_over <= 1'b0;
      r_winner    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_score1    <= w_score1_nxt;
      r_score2    <= w_score2_nxt;
      r_target    <= w_target_nxt;
      r_ball_rst  <= w_ball_rst_nxt;
      r_ball_run  <= w_ball_run_nxt;
      r_serve_dir <= w_serve_dir_nxt;
      r_game_over <= w_game_over_nxt;
      r_winner    <= w_winner_nxt;
    end
  end

  assign o_score1    = r_score1;
  assign o_score2    = r_score2;
  assign o_ball_rst  = r_ball_rst;
  assign o_ball_run  = r_ball_run;
  assign o_serve_dir = r_serve_dir;
  assign o_game_over = r_game_over;
  assign o_winner    = r_winner;
  assign o_state     = r_state;

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter AUTO_SERVE_FRAMES, default 120: frame_tick pulses spent in SERVE before an automatic serve.
REQ-002 Parameter POINT_PAUSE_FRAMES, default 60: frame_tick pulses spent in POINT after a goal.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  level; 1 enables a match, 0 aborts it.
REQ-006 serve  input  1  serve button, raw level; only its rising edge is used.
REQ-007 serve_type  input  1  0 = manual serve only; 1 = auto serve after timeout, manual edge also accepted.
REQ-008 max_score  input  2  winning score: 00->3, 01->5, 10->7, 11->9; sampled on IDLE->SERVE only.
REQ-009 frame_tick  input  1  one-cycle pulse per video frame.
REQ-010 goal_p1  input  1  one-cycle pulse, ball entered player-1 goal (player 2 scores).
REQ-011 goal_p2  input  1  one-cycle pulse, ball entered player-2 goal (player 1 scores).
REQ-012 score1, score2  output  4 each  player scores, binary.
REQ-013 ball_rst  output  1  one-cycle pulse: re-centre ball and bats.
REQ-014 ball_run  output  1  level; ball motion enabled.
REQ-015 serve_dir  output  1  0 = serve toward player 1, 1 = toward player 2.
REQ-016 game_over  output  1  level, high in GAME_OVER.
REQ-017 winner  output  1  0 = player 1, 1 = player 2; valid while game_over = 1.
REQ-018 state  output  3  current FSM state encoding, for debug and display.

Function
REQ-019 FSM states: IDLE, SERVE, PLAY, POINT, GAME_OVER; all outputs registered.
REQ-020 IDLE: ball_run = 0; when start = 1, go to SERVE, latch the target score, clear both scores, set serve_dir = 0, pulse ball_rst on the transition edge.
REQ-021 SERVE: ball_run = 0; a serve rising edge moves to PLAY on the next edge; a serve level already high on entry does not count as an edge.
REQ-022 SERVE with serve_type = 1: the timer counts frame_tick; the tick that reaches AUTO_SERVE_FRAMES moves to PLAY; the timer clears on every SERVE entry.
REQ-023 PLAY: ball_run = 1; goal_p1 increments score2, goal_p2 increments score1, on the same edge the FSM enters POINT.
REQ-024 goal_p1 and goal_p2 in the same cycle: no score change, serve_dir unchanged, enter POINT (replay).
REQ-025 Conceding player serves next: serve_dir <= 0 on goal_p1, 1 on goal_p2.
REQ-026 Goal pulses outside PLAY are ignored.
REQ-027 POINT: ball_run = 0; after POINT_PAUSE_FRAMES frame_ticks, go to GAME_OVER if either score equals the target; otherwise go to SERVE and pulse ball_rst.
REQ-028 GAME_OVER: game_over = 1, winner = the side at target, scores frozen; leave only via start = 0.
REQ-029 start = 0 in any non-IDLE state: go to IDLE on the next edge, ball_run = 0, scores held for display until the next match start.
REQ-030 Scores saturate at 9 and never wrap; the target cap guarantees this is unreachable in normal play.
REQ-031 ball_rst is never high for two consecutive cycles.

Reset
REQ-032 On rst = 0, asynchronously: state = IDLE, score1 = score2 = 0, ball_rst = 0, ball_run = 0, serve_dir = 0, game_over = 0, winner = 0, timers = 0, serve edge register = 1 (no false edge after reset).

Structure
REQ-033 Shared package game_pkg holds the state encoding constants and the max_score-to-target lookup.
REQ-034 One sub-module, tick_timer: a frame_tick counter with clear and terminal-count output, instantiated once and shared by SERVE and POINT.
REQ-035 No combinational path from any input to any output.

Verification
REQ-036 Manual serve: start = 1, serve_type = 0, serve edge -> ball_run = 1 two cycles after the edge, ball_rst pulsed exactly once.
REQ-037 Auto serve: serve_type = 1, no serve input, AUTO_SERVE_FRAMES = 4 -> PLAY entered on the 4th frame_tick.
REQ-038 Scoring: goal_p1 in PLAY -> score2 = 1, serve_dir = 0, ball_run = 0, and SERVE reached after POINT_PAUSE_FRAMES ticks.
REQ-039 Win: max_score = 00, three goal_p2 pulses -> score1 = 3, game_over = 1, winner = 0; further goals ignored.
REQ-040 Simultaneous goals -> scores unchanged, POINT entered.
REQ-041 Abort and reset: start = 0 mid-PLAY -> IDLE next edge; rst = 0 mid-POINT -> all outputs at REQ-032 values with no clock edge.
